cpu_axi_bridge: RTL and testbench

- Converts the core's two SRAM-like channels into one AXI3 master port.
  - Instruction channel: read-only.
  - Data channel: read and write.
- Sits between the five-stage core and the AXI interconnect, replacing the direct inst/data SRAM ports.
- Arbitrates reads between the two channels, routes read data back by AXI ID, and serialises writes with read-after-write protection.
- Generalises the fixed 32-bit SRAM link through width and ID parameters.

---
 rtl/cpu_axi_bridge_pkg.sv | 27 ++
 rtl/cpu_axi_bridge_rd_arbiter.sv | 109 ++++++++++
 rtl/cpu_axi_bridge.sv | 199 +++++++++++++++++++
 tb/tb_cpu_axi_bridge.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_axi_bridge_pkg.sv
// Shared definitions for the CPU-to-AXI3 bridge.
// Holds the FSM encodings, the fixed AXI field values and the default IDs.
package cpu_axi_bridge_pkg;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_REQ  = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    localparam logic [1:0] BURST_INCR      = 2'b01;
    localparam logic [7:0] LEN_SINGLE      = 8'd0;
    localparam logic [3:0] DEFAULT_INST_ID = 4'd0;
    localparam logic [3:0] DEFAULT_DATA_ID = 4'd1;

    // The SRAM-side size is log2(bytes) in 2 bits; AXI widens it to 3 bits.
    function automatic logic [2:0] axi_size(input logic [1:0] sram_size);
        return {1'b0, sram_size};
    endfunction

endpackage

// File: rtl/cpu_axi_bridge_rd_arbiter.sv
// Read-side arbiter and AR/R FSM: grants one of the two read requesters and
// keeps exactly one AXI read outstanding.
module axi_rd_arbiter
    import cpu_axi_bridge_pkg::*;
#(
    parameter int         ADDR_W  = 32,
    parameter logic [3:0] INST_ID = DEFAULT_INST_ID,
    parameter logic [3:0] DATA_ID = DEFAULT_DATA_ID
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [1:0]        inst_size,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [1:0]        data_size,
    input  logic              wr_idle,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic              rd_addr_ok,
    output logic              rd_data_ok,
    output logic              rd_data_busy,
    output logic [3:0]        arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [2:0]        arsize,
    output logic              arvalid,
    input  logic              arready,
    input  logic [3:0]        rid,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready
);

    rd_state_e         state_q, state_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [2:0]        arsize_q, arsize_d;
    logic [3:0]        arid_q, arid_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= R_IDLE;
            araddr_q <= '0;
            arsize_q <= '0;
            arid_q   <= '0;
        end else begin
            state_q  <= state_d;
            araddr_q <= araddr_d;
            arsize_q <= arsize_d;
            arid_q   <= arid_d;
        end
    end

    // Data reads win the grant, but only once no write is in flight so a
    // read never overtakes an earlier store.
    always_comb begin
        state_d      = state_q;
        araddr_d     = araddr_q;
        arsize_d     = arsize_q;
        arid_d       = arid_q;
        inst_addr_ok = 1'b0;
        rd_addr_ok   = 1'b0;
        inst_data_ok = 1'b0;
        rd_data_ok   = 1'b0;
        unique case (state_q)
            R_IDLE: begin
                if (data_req && !data_wr && wr_idle) begin
                    rd_addr_ok = 1'b1;
                    araddr_d   = data_addr;
                    arsize_d   = axi_size(data_size);
                    arid_d     = DATA_ID;
                    state_d    = R_ADDR;
                end else if (inst_req) begin
                    inst_addr_ok = 1'b1;
                    araddr_d     = inst_addr;
                    arsize_d     = axi_size(inst_size);
                    arid_d       = INST_ID;
                    state_d      = R_ADDR;
                end
            end
            R_ADDR: begin
                if (arready) state_d = R_DATA;
            end
            R_DATA: begin
                if (rvalid && rlast) begin
                    inst_data_ok = (rid == INST_ID);
                    rd_data_ok   = (rid == DATA_ID);
                    state_d      = R_IDLE;
                end
            end
            default: state_d = R_IDLE;
        endcase
        if (reset) begin
            inst_addr_ok = 1'b0;
            rd_addr_ok   = 1'b0;
            inst_data_ok = 1'b0;
            rd_data_ok   = 1'b0;
        end
    end

    assign arid         = arid_q;
    assign araddr       = araddr_q;
    assign arsize       = arsize_q;
    assign arvalid      = (state_q == R_ADDR) && !reset;
    assign rready       = (state_q == R_DATA) && !reset;
    assign rd_data_busy = (state_q != R_IDLE) && (arid_q == DATA_ID);

endmodule

// File: rtl/cpu_axi_bridge.sv
// Bridge from the core's SRAM-like instruction and data channels to one AXI3
// master port. Reads go through axi_rd_arbiter; the write FSM lives here.
module cpu_axi_bridge
    import cpu_axi_bridge_pkg::*;
#(
    parameter int         ADDR_W  = 32,
    parameter int         DATA_W  = 32,
    parameter logic [3:0] INST_ID = DEFAULT_INST_ID,
    parameter logic [3:0] DATA_ID = DEFAULT_DATA_ID
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    input  logic [1:0]          inst_size,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,
    output logic [DATA_W-1:0]   inst_rdata,
    input  logic                data_req,
    input  logic                data_wr,
    input  logic [1:0]          data_size,
    input  logic [DATA_W/8-1:0] data_wstrb,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [DATA_W-1:0]   data_rdata,
    output logic [3:0]          arid,
    output logic [ADDR_W-1:0]   araddr,
    output logic [7:0]          arlen,
    output logic [2:0]          arsize,
    output logic [1:0]          arburst,
    output logic [1:0]          arlock,
    output logic [3:0]          arcache,
    output logic [2:0]          arprot,
    output logic                arvalid,
    input  logic                arready,
    input  logic [3:0]          rid,
    input  logic [DATA_W-1:0]   rdata,
    input  logic                rlast,
    input  logic                rvalid,
    output logic                rready,
    output logic [3:0]          awid,
    output logic [ADDR_W-1:0]   awaddr,
    output logic [7:0]          awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic [1:0]          awlock,
    output logic [3:0]          awcache,
    output logic [2:0]          awprot,
    output logic                awvalid,
    input  logic                awready,
    output logic [3:0]          wid,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wlast,
    output logic                wvalid,
    input  logic                wready,
    input  logic                bvalid,
    output logic                bready
);

    wr_state_e           w_state_q, w_state_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
    logic [2:0]          awsize_q, awsize_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
    logic                wr_addr_ok, wr_data_ok;
    logic                rd_addr_ok, rd_data_ok, rd_data_busy;

    axi_rd_arbiter #(
        .ADDR_W (ADDR_W),
        .INST_ID(INST_ID),
        .DATA_ID(DATA_ID)
    ) u_rd_arbiter (
        .clk         (clk),
        .reset       (reset),
        .inst_req    (inst_req),
        .inst_addr   (inst_addr),
        .inst_size   (inst_size),
        .data_req    (data_req),
        .data_wr     (data_wr),
        .data_addr   (data_addr),
        .data_size   (data_size),
        .wr_idle     (w_state_q == W_IDLE),
        .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok),
        .rd_addr_ok  (rd_addr_ok),
        .rd_data_ok  (rd_data_ok),
        .rd_data_busy(rd_data_busy),
        .arid        (arid),
        .araddr      (araddr),
        .arsize      (arsize),
        .arvalid     (arvalid),
        .arready     (arready),
        .rid         (rid),
        .rlast       (rlast),
        .rvalid      (rvalid),
        .rready      (rready)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            w_state_q <= W_IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            awaddr_q  <= '0;
            awsize_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            awaddr_q  <= awaddr_d;
            awsize_q  <= awsize_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
        end
    end

    // AW and W handshake independently; the response is only awaited once
    // both have been taken by the interconnect.
    always_comb begin
        w_state_d  = w_state_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        awaddr_d   = awaddr_q;
        awsize_d   = awsize_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        wr_addr_ok = 1'b0;
        wr_data_ok = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
                if (data_req && data_wr && !rd_data_busy) begin
                    wr_addr_ok = 1'b1;
                    awaddr_d   = data_addr;
                    awsize_d   = axi_size(data_size);
                    wdata_d    = data_wdata;
                    wstrb_d    = data_wstrb;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                    w_state_d  = W_REQ;
                end
            end
            W_REQ: begin
                if (awvalid && awready) aw_done_d = 1'b1;
                if (wvalid && wready)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (bvalid) begin
                    wr_data_ok = 1'b1;
                    w_state_d  = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        if (reset) begin
            wr_addr_ok = 1'b0;
            wr_data_ok = 1'b0;
        end
    end

    assign awvalid      = (w_state_q == W_REQ) && !aw_done_q && !reset;
    assign wvalid       = (w_state_q == W_REQ) && !w_done_q && !reset;
    assign bready       = (w_state_q == W_RESP) && !reset;
    assign awaddr       = awaddr_q;
    assign awsize       = awsize_q;
    assign wdata        = wdata_q;
    assign wstrb        = wstrb_q;

    assign data_addr_ok = rd_addr_ok | wr_addr_ok;
    assign data_data_ok = rd_data_ok | wr_data_ok;
    assign inst_rdata   = rdata;
    assign data_rdata   = rdata;

    assign arlen   = LEN_SINGLE;
    assign arburst = BURST_INCR;
    assign arlock  = '0;
    assign arcache = '0;
    assign arprot  = '0;
    assign awid    = DATA_ID;
    assign awlen   = LEN_SINGLE;
    assign awburst = BURST_INCR;
    assign awlock  = '0;
    assign awcache = '0;
    assign awprot  = '0;
    assign wid     = DATA_ID;
    assign wlast   = 1'b1;

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Directed bench for cpu_axi_bridge: the bench plays both the core and a
// hand-driven AXI slave, checking outputs mid-cycle against fixed values.
module tb_cpu_axi_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [1:0]  inst_size;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic [3:0]  arid, rid, awid, wid, arcache, awcache;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, awburst, arlock, awlock;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [3:0]  wstrb;

    int n_compared   = 0;
    int n_mismatched = 0;

    cpu_axi_bridge dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_size(inst_size),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
        .arready(arready),
        .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid),
        .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
        .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drive point is just after the active edge; checks happen on the falling edge.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic valid, input logic [3:0] id, input logic [31:0] data);
        rvalid = valid;
        rlast  = valid;
        rid    = id;
        rdata  = data;
    endtask

    initial begin
        reset = 1'b1;
        inst_req = 0; inst_addr = 0; inst_size = 2'd2;
        data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 0;
        data_addr = 0; data_wdata = 0;
        arready = 0; awready = 0; wready = 0; bvalid = 0;
        applyStimulus(1'b0, 4'd0, 32'h0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        sample();
        checkOutput("rst_arvalid", arvalid, 0);
        checkOutput("rst_rready", rready, 0);
        checkOutput("rst_awvalid", awvalid, 0);
        checkOutput("rst_wvalid", wvalid, 0);
        checkOutput("rst_bready", bready, 0);
        checkOutput("rst_araddr", araddr, 0);
        checkOutput("rst_awaddr", awaddr, 0);
        checkOutput("fixed_arlen", arlen, 0);
        checkOutput("fixed_arburst", arburst, 2'b01);
        checkOutput("fixed_wlast", wlast, 1);
        checkOutput("fixed_awid", awid, 1);

        // Single instruction read with a zero-wait slave
        nextCycle(); inst_req = 1; inst_addr = 32'h1c000000;
        sample();
        checkOutput("t1_inst_addr_ok", inst_addr_ok, 1);
        checkOutput("t1_arvalid_c0", arvalid, 0);
        nextCycle(); inst_req = 0; arready = 1;
        sample();
        checkOutput("t1_arvalid_c1", arvalid, 1);
        checkOutput("t1_araddr", araddr, 32'h1c000000);
        checkOutput("t1_arid", arid, 0);
        checkOutput("t1_arsize", arsize, 3'd2);
        nextCycle(); arready = 0; applyStimulus(1'b1, 4'd0, 32'h02800c0c);
        sample();
        checkOutput("t1_rready", rready, 1);
        checkOutput("t1_inst_data_ok", inst_data_ok, 1);
        checkOutput("t1_inst_rdata", inst_rdata, 32'h02800c0c);
        checkOutput("t1_data_data_ok", data_data_ok, 0);
        nextCycle(); applyStimulus(1'b0, 4'd0, 32'h0);
        sample();
        checkOutput("t1_inst_data_ok_clr", inst_data_ok, 0);
        checkOutput("t1_rready_clr", rready, 0);

        // Simultaneous inst and data reads: data goes first
        nextCycle(); inst_req = 1; inst_addr = 32'h1c000004;
        data_req = 1; data_wr = 0; data_addr = 32'h80000010;
        sample();
        checkOutput("t2_data_addr_ok", data_addr_ok, 1);
        checkOutput("t2_inst_addr_ok_c0", inst_addr_ok, 0);
        nextCycle(); data_req = 0; arready = 1;
        sample();
        checkOutput("t2_arid_data", arid, 1);
        checkOutput("t2_araddr_data", araddr, 32'h80000010);
        checkOutput("t2_inst_addr_ok_c1", inst_addr_ok, 0);
        nextCycle(); arready = 0; applyStimulus(1'b1, 4'd1, 32'h11112222);
        sample();
        checkOutput("t2_data_data_ok", data_data_ok, 1);
        checkOutput("t2_data_rdata", data_rdata, 32'h11112222);
        checkOutput("t2_inst_data_ok", inst_data_ok, 0);
        checkOutput("t2_inst_addr_ok_c2", inst_addr_ok, 0);
        nextCycle(); applyStimulus(1'b0, 4'd0, 32'h0);
        sample();
        checkOutput("t2_inst_addr_ok_late", inst_addr_ok, 1);
        nextCycle(); inst_req = 0; arready = 1;
        sample();
        checkOutput("t2_arid_inst", arid, 0);
        checkOutput("t2_araddr_inst", araddr, 32'h1c000004);
        nextCycle(); arready = 0; applyStimulus(1'b1, 4'd0, 32'h33334444);
        sample();
        checkOutput("t2_inst_data_ok", inst_data_ok, 1);
        nextCycle(); applyStimulus(1'b0, 4'd0, 32'h0);

        // Data write, awready three cycles after wready
        data_req = 1; data_wr = 1; data_addr = 32'h80000020;
        data_wdata = 32'hdeadbeef; data_wstrb = 4'hf;
        sample();
        checkOutput("t3_data_addr_ok", data_addr_ok, 1);
        nextCycle(); data_req = 0; data_wr = 0; wready = 1;
        sample();
        checkOutput("t3_awvalid_c1", awvalid, 1);
        checkOutput("t3_wvalid_c1", wvalid, 1);
        checkOutput("t3_awaddr", awaddr, 32'h80000020);
        checkOutput("t3_wdata", wdata, 32'hdeadbeef);
        checkOutput("t3_wstrb", wstrb, 4'hf);
        nextCycle(); wready = 0;
        for (int i = 0; i < 2; i++) begin
            sample();
            checkOutput("t3_wvalid_dropped", wvalid, 0);
            checkOutput("t3_awvalid_held", awvalid, 1);
            checkOutput("t3_bready_early", bready, 0);
            nextCycle();
        end
        awready = 1;
        sample();
        checkOutput("t3_awvalid_hs", awvalid, 1);
        checkOutput("t3_bready_hs", bready, 0);
        nextCycle(); awready = 0;
        sample();
        checkOutput("t3_awvalid_done", awvalid, 0);
        checkOutput("t3_bready", bready, 1);
        checkOutput("t3_data_ok_wait", data_data_ok, 0);
        nextCycle(); bvalid = 1;
        sample();
        checkOutput("t3_data_data_ok", data_data_ok, 1);
        nextCycle(); bvalid = 0;
        sample();
        checkOutput("t3_data_ok_clr", data_data_ok, 0);
        checkOutput("t3_bready_clr", bready, 0);

        // Write then read of the same address: read waits for the write
        nextCycle(); data_req = 1; data_wr = 1; data_addr = 32'h80000020;
        data_wdata = 32'hcafef00d;
        sample();
        checkOutput("t4_wr_addr_ok", data_addr_ok, 1);
        nextCycle(); data_wr = 0; awready = 1; wready = 1;
        sample();
        checkOutput("t4_rd_blocked_req", data_addr_ok, 0);
        checkOutput("t4_arvalid_req", arvalid, 0);
        nextCycle(); awready = 0; wready = 0; bvalid = 1;
        sample();
        checkOutput("t4_rd_blocked_resp", data_addr_ok, 0);
        checkOutput("t4_wr_data_ok", data_data_ok, 1);
        nextCycle(); bvalid = 0;
        sample();
        checkOutput("t4_rd_addr_ok", data_addr_ok, 1);
        nextCycle(); data_req = 0; arready = 1;
        sample();
        checkOutput("t4_arvalid", arvalid, 1);
        checkOutput("t4_araddr", araddr, 32'h80000020);
        checkOutput("t4_arid", arid, 1);
        nextCycle(); arready = 0; applyStimulus(1'b1, 4'd1, 32'hcafef00d);
        sample();
        checkOutput("t4_rd_data_ok", data_data_ok, 1);
        checkOutput("t4_rdata", data_rdata, 32'hcafef00d);
        nextCycle(); applyStimulus(1'b0, 4'd0, 32'h0);

        // AR stalled five cycles with a competing data read pending
        inst_req = 1; inst_addr = 32'h1c000100;
        sample();
        checkOutput("t5_inst_addr_ok", inst_addr_ok, 1);
        nextCycle(); inst_req = 0; data_req = 1; data_wr = 0; data_addr = 32'h80000040;
        for (int i = 0; i < 5; i++) begin
            sample();
            checkOutput("t5_arvalid_stall", arvalid, 1);
            checkOutput("t5_araddr_stall", araddr, 32'h1c000100);
            checkOutput("t5_arid_stall", arid, 0);
            checkOutput("t5_data_addr_ok_stall", data_addr_ok, 0);
            nextCycle();
        end
        arready = 1;
        sample();
        checkOutput("t5_arvalid_hs", arvalid, 1);
        nextCycle(); arready = 0; applyStimulus(1'b1, 4'd0, 32'h55556666);
        sample();
        checkOutput("t5_inst_data_ok", inst_data_ok, 1);
        checkOutput("t5_data_addr_ok_rdata", data_addr_ok, 0);
        nextCycle(); applyStimulus(1'b0, 4'd0, 32'h0);
        sample();
        checkOutput("t5_data_addr_ok_late", data_addr_ok, 1);
        nextCycle(); data_req = 0; arready = 1;
        sample();
        checkOutput("t5_araddr_data", araddr, 32'h80000040);
        nextCycle(); arready = 0; applyStimulus(1'b1, 4'd1, 32'h77778888);
        sample();
        checkOutput("t5_data_data_ok", data_data_ok, 1);
        nextCycle(); applyStimulus(1'b0, 4'd0, 32'h0);

        // Unknown rid is swallowed without any data_ok
        inst_req = 1; inst_addr = 32'h1c000200;
        nextCycle(); inst_req = 0; arready = 1;
        nextCycle(); arready = 0; applyStimulus(1'b1, 4'd5, 32'h9999aaaa);
        sample();
        checkOutput("t6_unk_inst_ok", inst_data_ok, 0);
        checkOutput("t6_unk_data_ok", data_data_ok, 0);
        nextCycle(); applyStimulus(1'b0, 4'd0, 32'h0); inst_req = 1; inst_addr = 32'h1c000204;
        sample();
        checkOutput("t6_back_to_idle", inst_addr_ok, 1);
        nextCycle(); inst_req = 0; arready = 1;
        nextCycle(); arready = 0; applyStimulus(1'b1, 4'd0, 32'h0);
        nextCycle(); applyStimulus(1'b0, 4'd0, 32'h0);

        // Reset while waiting in R_DATA
        inst_req = 1; inst_addr = 32'h1c000300;
        nextCycle(); inst_req = 0; arready = 1;
        nextCycle(); arready = 0;
        sample();
        checkOutput("t7_in_rdata", rready, 1);
        nextCycle(); reset = 1;
        nextCycle(); reset = 0; applyStimulus(1'b1, 4'd0, 32'hbbbbcccc);
        sample();
        checkOutput("t7_rready", rready, 0);
        checkOutput("t7_arvalid", arvalid, 0);
        checkOutput("t7_bready", bready, 0);
        checkOutput("t7_inst_data_ok", inst_data_ok, 0);
        checkOutput("t7_data_data_ok", data_data_ok, 0);
        checkOutput("t7_araddr_clr", araddr, 0);
        nextCycle(); applyStimulus(1'b0, 4'd0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
